// File: rtl/cmp_search_seq_pkg.sv
// Shared state encodings for the sequential search controller.
package cmp_search_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cmp_search_seq_am25ls2521.sv
// Cascadable WIDTH-bit equality comparator slice: eout_ low only when enabled and a==b.
module am25ls2521 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ein_,
    output logic             eout_
);

    assign eout_ = ein_ | (|(a ^ b));

endmodule

// File: rtl/cmp_search_seq.sv
// Associative lookup that time-shares one equality comparator over a small tagged table,
// reporting the lowest matching index and the total number of matches.
module cmp_search_seq
    import cmp_search_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             wr_,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             clr_,
    input  logic [WIDTH-1:0] key,
    input  logic             first,
    input  logic             start_,
    output logic             busy,
    output logic             done,
    output logic             match_,
    output logic [AW-1:0]    idx,
    output logic [AW:0]      count
);

    state_e             state_q;
    logic [AW-1:0]      ptr_q;
    logic [WIDTH-1:0]   key_q;
    logic               first_q;
    logic               match_q;
    logic [AW-1:0]      idx_q;
    logic [AW:0]        count_q;
    logic [DEPTH-1:0]   valid_q;
    logic [WIDTH-1:0]   table_mem [DEPTH];

    logic               idle;
    logic               tbl_we;
    logic               cmp_eout_;
    logic               hit;
    logic               ptr_last;

    assign idle     = (state_q == ST_IDLE);
    // Invalidate-all takes priority over a write landing on the same edge.
    assign tbl_we   = idle && !wr_ && clr_;
    assign ptr_last = (ptr_q == AW'(DEPTH - 1));
    assign hit      = ~cmp_eout_;

    // Data array carries no reset; validity is tracked separately in valid_q.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            table_mem[waddr] <= wdata;
        end
    end

    am25ls2521 #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a     (table_mem[ptr_q]),
        .b     (key_q),
        .ein_  (~valid_q[ptr_q]),
        .eout_ (cmp_eout_)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            key_q   <= '0;
            first_q <= 1'b0;
            match_q <= 1'b1;
            idx_q   <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!clr_) begin
                        valid_q <= '0;
                    end else if (!wr_) begin
                        valid_q[waddr] <= 1'b1;
                    end
                    if (!start_) begin
                        key_q   <= key;
                        first_q <= first;
                        ptr_q   <= '0;
                        match_q <= 1'b1;
                        idx_q   <= '0;
                        count_q <= '0;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit) begin
                        count_q <= count_q + 1'b1;
                        if (match_q) begin
                            idx_q   <= ptr_q;
                            match_q <= 1'b0;
                        end
                    end
                    // ptr parks on the last entry rather than wrapping.
                    if ((hit && first_q) || ptr_last) begin
                        state_q <= ST_DONE;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q == ST_SCAN);
    assign done   = (state_q == ST_DONE);
    assign match_ = match_q;
    assign idx    = idx_q;
    assign count  = count_q;

endmodule

// File: tb/tb_cmp_search_seq.sv
// Directed bench for cmp_search_seq: table writes, full/first-mode scans, clear, and reset abort.
module tb_cmp_search_seq;

    logic       clk;
    logic       rst_;
    logic       wr_;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       clr_;
    logic [7:0] key;
    logic       first;
    logic       start_;
    logic       busy;
    logic       done;
    logic       match_;
    logic [3:0] idx;
    logic [4:0] count;

    int n_checks = 0;
    int n_err    = 0;
    int lat;

    cmp_search_seq #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clk    (clk),
        .rst_   (rst_),
        .wr_    (wr_),
        .waddr  (waddr),
        .wdata  (wdata),
        .clr_   (clr_),
        .key    (key),
        .first  (first),
        .start_ (start_),
        .busy   (busy),
        .done   (done),
        .match_ (match_),
        .idx    (idx),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_entry(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_ = 1'b0; waddr = a; wdata = d;
        @(negedge clk);
        wr_ = 1'b1;
    endtask

    task automatic clr_pulse(input logic with_wr, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        clr_ = 1'b0;
        if (with_wr) begin
            wr_ = 1'b0; waddr = a; wdata = d;
        end
        @(negedge clk);
        clr_ = 1'b1; wr_ = 1'b1;
    endtask

    // Returns cycles from the start edge E0 to the done cycle (k), or -1 on timeout.
    // poke=1 drives start_ and a write during the scan to show both are ignored.
    task automatic run_scan(input logic [7:0] k, input logic f, input int poke, output int l);
        @(negedge clk);
        key = k; first = f; start_ = 1'b0;
        @(posedge clk);
        #1 start_ = 1'b1;
        l = -1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (poke == 1 && j == 5) begin
                start_ = 1'b0; wr_ = 1'b0; waddr = 4'd0; wdata = 8'h11;
            end
            if (poke == 1 && j == 6) begin
                start_ = 1'b1; wr_ = 1'b1;
            end
            if (done) begin
                l = j - 1;
                break;
            end
        end
        $display("scan key=%02h first=%0d lat=%0d match_=%0d idx=%0d count=%0d",
                 k, f, l, match_, idx, count);
    endtask

    initial begin
        rst_ = 1'b0; wr_ = 1'b1; waddr = '0; wdata = '0; clr_ = 1'b1;
        key = '0; first = 1'b0; start_ = 1'b1;
        #12;
        chk("rst_busy",   busy,   0);
        chk("rst_done",   done,   0);
        chk("rst_match",  match_, 1);
        chk("rst_idx",    idx,    0);
        chk("rst_count",  count,  0);
        @(negedge clk);
        rst_ = 1'b1;

        // Valid entry found, then reset must clear the valid bits.
        wr_entry(4'd2, 8'h00);
        run_scan(8'h00, 1'b0, 0, lat);
        chk("pre_lat",   lat,    16);
        chk("pre_match", match_, 0);
        chk("pre_idx",   idx,    2);
        chk("pre_count", count,  1);
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        chk("rst2_match", match_, 1);
        chk("rst2_count", count,  0);
        chk("rst2_idx",   idx,    0);
        @(negedge clk);
        rst_ = 1'b1;
        run_scan(8'h00, 1'b0, 0, lat);
        chk("post_rst_lat",   lat,    16);
        chk("post_rst_match", match_, 1);
        chk("post_rst_count", count,  0);

        // Two A5 hits, full scan then first-mode.
        wr_entry(4'd3,  8'hA5);
        wr_entry(4'd9,  8'hA5);
        wr_entry(4'd12, 8'h3C);
        run_scan(8'hA5, 1'b0, 0, lat);
        chk("all_lat",   lat,    16);
        chk("all_match", match_, 0);
        chk("all_idx",   idx,    3);
        chk("all_count", count,  2);
        chk("all_busy",  busy,   0);
        run_scan(8'hA5, 1'b1, 0, lat);
        chk("first_lat",   lat,    4);
        chk("first_idx",   idx,    3);
        chk("first_count", count,  1);
        chk("first_busy",  busy,   0);
        repeat (3) @(negedge clk);
        chk("hold_count", count,  1);
        chk("hold_done",  done,   0);
        run_scan(8'h3C, 1'b1, 0, lat);
        chk("last3c_idx", idx, 12);

        // Clear, and clear-with-write on the same edge.
        wr_entry(4'd5, 8'h00);
        run_scan(8'h00, 1'b0, 0, lat);
        chk("w5_idx",   idx,   5);
        chk("w5_count", count, 1);
        clr_pulse(1'b0, 4'd0, 8'h00);
        run_scan(8'h00, 1'b0, 0, lat);
        chk("clr_match", match_, 1);
        chk("clr_count", count,  0);
        clr_pulse(1'b1, 4'd7, 8'h00);
        run_scan(8'h00, 1'b0, 0, lat);
        chk("clrwr_match", match_, 1);
        chk("clrwr_count", count,  0);

        // Full table of 7E; mid-scan start_ and wr_ ignored.
        for (int i = 0; i < 16; i++) wr_entry(4'(i), 8'h7E);
        run_scan(8'h7E, 1'b0, 1, lat);
        chk("full_lat",   lat,   16);
        chk("full_count", count, 16);
        chk("full_idx",   idx,   0);
        @(negedge clk);
        chk("no_retrig_busy", busy, 0);
        run_scan(8'h7E, 1'b1, 0, lat);
        chk("e0_lat",   lat,   1);
        chk("e0_count", count, 1);
        run_scan(8'h11, 1'b0, 0, lat);
        chk("ignwr_count", count, 0);

        // Reset mid-scan aborts immediately.
        @(negedge clk);
        key = 8'h7E; first = 1'b0; start_ = 1'b0;
        @(posedge clk);
        #1 start_ = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_busy_pre", busy, 1);
        rst_ = 1'b0;
        #1;
        chk("mid_busy",  busy,   0);
        chk("mid_done",  done,   0);
        chk("mid_match", match_, 1);
        chk("mid_count", count,  0);
        repeat (2) @(negedge clk);
        chk("mid_nodone", done, 0);
        rst_ = 1'b1;
        run_scan(8'hA5, 1'b0, 0, lat);
        chk("after_lat",   lat,   16);
        chk("after_count", count, 0);
        run_scan(8'h7E, 1'b0, 0, lat);
        chk("after7e_count", count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
